// File: rtl/matrix_accel_pkg.sv
// Shared definitions for the matrix multiply accelerator.
// Holds the bus bank encodings, CTRL/STATUS/IRQEN bit positions,
// the sequencer state type and the accumulator width helper.
package matrix_accel_pkg;

   localparam logic [2:0] BANK_CTRL   = 3'd0;
   localparam logic [2:0] BANK_A      = 3'd1;
   localparam logic [2:0] BANK_B      = 3'd2;
   localparam logic [2:0] BANK_C      = 3'd3;
   localparam logic [2:0] BANK_STATUS = 3'd4;
   localparam logic [2:0] BANK_IRQEN  = 3'd5;

   localparam int CTRL_START  = 24;
   localparam int CTRL_SIGNED = 25;
   localparam int CTRL_ACCUM  = 26;
   localparam int CTRL_SAT    = 27;

   localparam int ST_BUSY    = 0;
   localparam int ST_DONE    = 1;
   localparam int ST_ERR     = 2;
   localparam int ST_ABORTED = 3;

   localparam int IRQEN_EN    = 0;
   localparam int IRQEN_ABORT = 31;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   // Wide enough for MAX_K full-scale products plus a sign bit, so the
   // running sum never overflows in either signed or unsigned mode.
   function automatic int acc_width(input int dw, input int max_k);
      return 2 * dw + $clog2(max_k) + 1;
   endfunction

endpackage

// File: rtl/matrix_mac_pe.sv
// Multiply-accumulate element with write-back stage.
// Ports:
//   clk            clock
//   a, b           operands (DW bits), signed or unsigned per sgn
//   c_old          current C element, added at write-back when accum=1
//   sgn, accum, sat  arithmetic mode bits from CTRL
//   clr            restart the sum (first MAC cycle of a block)
//   en             accumulate this cycle's product
//   wb_val         saturated or wrapped acc (+ c_old) for write-back
module matrix_mac_pe
   import matrix_accel_pkg::*;
#(
   parameter int DW    = 32,
   parameter int MAX_K = 8
) (
   input  logic          clk,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] c_old,
   input  logic          sgn,
   input  logic          accum,
   input  logic          sat,
   input  logic          clr,
   input  logic          en,
   output logic [DW-1:0] wb_val
);

   localparam int AW = acc_width(DW, MAX_K);

   logic signed [DW:0]     a_x, b_x;
   logic signed [2*DW+1:0] prod;
   logic signed [AW-1:0]   prod_x, acc;
   logic signed [AW:0]     c_x, sum;

   function automatic logic [DW-1:0] clamp(input logic signed [AW:0] v,
                                           input logic sg, input logic st);
      logic signed [AW:0] one, hi, lo;
      one = 1;
      hi  = sg ? (one <<< (DW - 1)) - one : (one <<< DW) - one;
      lo  = sg ? -(one <<< (DW - 1)) : '0;
      if (!st)   return v[DW-1:0];
      if (v > hi) return hi[DW-1:0];
      if (v < lo) return lo[DW-1:0];
      return v[DW-1:0];
   endfunction

   // One extra operand bit lets a single signed multiplier serve both modes.
   always_comb begin
      a_x    = sgn ? {a[DW-1], a} : {1'b0, a};
      b_x    = sgn ? {b[DW-1], b} : {1'b0, b};
      prod   = a_x * b_x;
      prod_x = AW'(prod);
      c_x    = sgn ? (AW+1)'($signed(c_old)) : (AW+1)'(c_old);
      sum    = {acc[AW-1], acc} + (accum ? c_x : '0);
      wb_val = clamp(sum, sgn, sat);
   end

   always_ff @(posedge clk) begin
      if (clr)     acc <= en ? prod_x : '0;
      else if (en) acc <= acc + prod_x;
   end

endmodule

// File: rtl/matrix_mac_accel.sv
// Wishbone-slave matrix multiply accelerator: C = A*B or C += A*B.
// Ports:
//   i_wb_clk, i_wb_rst    clock, synchronous active-high reset
//   i_wb_adr              byte address: [12:10] bank, [9:2] element index
//   i_wb_dat, i_wb_we     write data, write enable
//   i_wb_stb              strobe
//   o_wb_rdt, o_wb_ack    registered read data, one-cycle ack
//   o_irq                 STATUS.done & IRQEN.en
module matrix_mac_accel
   import matrix_accel_pkg::*;
#(
   parameter int DW    = 32,
   parameter int MAX_M = 8,
   parameter int MAX_K = 8,
   parameter int MAX_N = 8
) (
   input  logic        i_wb_clk,
   input  logic        i_wb_rst,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic        i_wb_we,
   input  logic        i_wb_stb,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic        o_irq
);

   localparam int A_SZ = MAX_M * MAX_K;
   localparam int B_SZ = MAX_K * MAX_N;
   localparam int C_SZ = MAX_M * MAX_N;
   localparam int AI_W = (A_SZ > 1) ? $clog2(A_SZ) : 1;
   localparam int BI_W = (B_SZ > 1) ? $clog2(B_SZ) : 1;
   localparam int CI_W = (C_SZ > 1) ? $clog2(C_SZ) : 1;

   logic [DW-1:0] mem_a [A_SZ];
   logic [DW-1:0] mem_b [B_SZ];
   logic [DW-1:0] mem_c [C_SZ];

   state_t        state, state_d;
   logic [7:0]    dim_m, dim_k, dim_n;
   logic          sgn, accum, sat;
   logic          done, err, aborted, irq_en;
   logic [7:0]    i_cnt, j_cnt, k_cnt;

   logic [2:0]    bank;
   logic [7:0]    idx;
   logic          wr, busy, a_ok, b_ok, c_ok;
   logic          ctrl_wr, status_wr, start_req, dims_ok, abort_req;
   logic          last_k, last_j, last_i, run_end;
   logic [AI_W-1:0] a_rd;
   logic [BI_W-1:0] b_rd;
   logic [CI_W-1:0] c_rd;
   logic [DW-1:0] wb_val;
   logic [31:0]   rd_data;
   logic          unused_bits;

   function automatic logic dim_ok(input logic [7:0] v, input int mx);
      return (v != 8'd0) && (int'(v) <= mx);
   endfunction

   function automatic logic [31:0] ext(input logic [DW-1:0] v, input logic sg);
      return sg ? 32'($signed(v)) : 32'(v);
   endfunction

   assign unused_bits = ^{i_wb_adr[31:13], i_wb_adr[1:0], i_wb_dat[30:28]};

   // Writes commit at the end of the ack cycle, so state changes caused by
   // an access become visible the cycle after the ack.
   assign bank      = i_wb_adr[12:10];
   assign idx       = i_wb_adr[9:2];
   assign wr        = i_wb_stb & i_wb_we & o_wb_ack;
   assign busy      = (state == S_RUN);
   assign a_ok      = int'(idx) < A_SZ;
   assign b_ok      = int'(idx) < B_SZ;
   assign c_ok      = int'(idx) < C_SZ;
   assign ctrl_wr   = wr && bank == BANK_CTRL && !busy;
   assign status_wr = wr && bank == BANK_STATUS;
   assign start_req = ctrl_wr && i_wb_dat[CTRL_START];
   assign dims_ok   = dim_ok(i_wb_dat[7:0], MAX_M) && dim_ok(i_wb_dat[15:8], MAX_K)
                      && dim_ok(i_wb_dat[23:16], MAX_N);
   assign abort_req = wr && bank == BANK_IRQEN && i_wb_dat[IRQEN_ABORT] && busy;

   // k_cnt runs 0..K: K MAC cycles then one write-back cycle per element.
   assign last_k  = (k_cnt == dim_k);
   assign last_j  = (j_cnt == dim_n - 8'd1);
   assign last_i  = (i_cnt == dim_m - 8'd1);
   assign run_end = busy && last_k && last_j && last_i;
   assign a_rd    = AI_W'(int'(i_cnt) * MAX_K + int'(k_cnt));
   assign b_rd    = BI_W'(int'(k_cnt) * MAX_N + int'(j_cnt));
   assign c_rd    = CI_W'(int'(i_cnt) * MAX_N + int'(j_cnt));
   assign o_irq   = done & irq_en;

   matrix_mac_pe #(.DW(DW), .MAX_K(MAX_K)) u_pe (
      .clk    (i_wb_clk),
      .a      (mem_a[a_rd]),
      .b      (mem_b[b_rd]),
      .c_old  (mem_c[c_rd]),
      .sgn    (sgn),
      .accum  (accum),
      .sat    (sat),
      .clr    (k_cnt == 8'd0),
      .en     (busy && !last_k),
      .wb_val (wb_val)
   );

   always_ff @(posedge i_wb_clk) begin
      if (i_wb_rst) state <= S_IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (start_req && dims_ok) state_d = S_RUN;
         S_RUN:   if (abort_req) state_d = S_IDLE;
                  else if (run_end) state_d = S_DONE;
         S_DONE:  state_d = (start_req && dims_ok) ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_wb_clk) begin
      if (i_wb_rst) begin
         {dim_m, dim_k, dim_n}     <= '0;
         {sgn, accum, sat}         <= '0;
         {done, err, aborted}      <= '0;
         irq_en                    <= 1'b0;
         {i_cnt, j_cnt, k_cnt}     <= '0;
         o_wb_ack                  <= 1'b0;
         o_wb_rdt                  <= '0;
      end else begin
         o_wb_ack <= i_wb_stb & ~o_wb_ack;
         if (i_wb_stb && !o_wb_ack) o_wb_rdt <= rd_data;

         if (ctrl_wr) begin
            dim_m <= i_wb_dat[7:0];
            dim_k <= i_wb_dat[15:8];
            dim_n <= i_wb_dat[23:16];
            sgn   <= i_wb_dat[CTRL_SIGNED];
            accum <= i_wb_dat[CTRL_ACCUM];
            sat   <= i_wb_dat[CTRL_SAT];
         end
         if (wr && bank == BANK_IRQEN) irq_en <= i_wb_dat[IRQEN_EN];

         if (state_d == S_RUN && !busy) begin
            {i_cnt, j_cnt, k_cnt} <= '0;
         end else if (busy) begin
            if (!last_k) begin
               k_cnt <= k_cnt + 8'd1;
            end else begin
               k_cnt <= '0;
               if (last_j) begin
                  j_cnt <= '0;
                  i_cnt <= i_cnt + 8'd1;
               end else begin
                  j_cnt <= j_cnt + 8'd1;
               end
            end
         end

         // W1C first so a same-cycle hardware set takes priority.
         if (status_wr && i_wb_dat[ST_DONE])    done    <= 1'b0;
         if (status_wr && i_wb_dat[ST_ERR])     err     <= 1'b0;
         if (status_wr && i_wb_dat[ST_ABORTED]) aborted <= 1'b0;
         if (state == S_DONE)                   done    <= 1'b1;
         if (start_req && !dims_ok)             err     <= 1'b1;
         if (abort_req)                         aborted <= 1'b1;
      end
   end

   always_ff @(posedge i_wb_clk) begin
      if (wr && !busy && bank == BANK_A && a_ok) mem_a[idx[AI_W-1:0]] <= i_wb_dat[DW-1:0];
      if (wr && !busy && bank == BANK_B && b_ok) mem_b[idx[BI_W-1:0]] <= i_wb_dat[DW-1:0];
      if (wr && !busy && bank == BANK_C && c_ok) mem_c[idx[CI_W-1:0]] <= i_wb_dat[DW-1:0];
      else if (busy && last_k)                   mem_c[c_rd]          <= wb_val;
   end

   always_comb begin
      rd_data = '0;
      case (bank)
         BANK_CTRL:   rd_data = {4'b0, sat, accum, sgn, 1'b0, dim_n, dim_k, dim_m};
         BANK_A:      if (a_ok) rd_data = ext(mem_a[idx[AI_W-1:0]], sgn);
         BANK_B:      if (b_ok) rd_data = ext(mem_b[idx[BI_W-1:0]], sgn);
         BANK_C:      if (c_ok) rd_data = ext(mem_c[idx[CI_W-1:0]], sgn);
         BANK_STATUS: rd_data = {28'b0, aborted, err, done, busy};
         BANK_IRQEN:  rd_data = {31'b0, irq_en};
         default:     rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_matrix_mac_accel.sv
module tb_matrix_mac_accel;

   localparam int DW = 8;
   localparam int MM = 8;
   localparam int MK = 8;
   localparam int MN = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] adr, dat_w, rdt;
   logic        we, stb, ack, irq;

   int checks = 0;
   int errors = 0;

   logic [7:0] ma [64];
   logic [7:0] mb [64];
   logic [7:0] mc [64];
   bit         cur_sg;

   always #5 clk = ~clk;

   matrix_mac_accel #(.DW(DW), .MAX_M(MM), .MAX_K(MK), .MAX_N(MN)) dut (
      .i_wb_clk (clk),
      .i_wb_rst (rst),
      .i_wb_adr (adr),
      .i_wb_dat (dat_w),
      .i_wb_we  (we),
      .i_wb_stb (stb),
      .o_wb_rdt (rdt),
      .o_wb_ack (ack),
      .o_irq    (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] addr(input int bank, input int idx);
      return 32'((bank << 10) | (idx << 2));
   endfunction

   function automatic logic [31:0] ctrl_word(input int m, input int k, input int n,
                                             input bit go, input bit sg, input bit ac, input bit st);
      return {4'b0, st, ac, sg, go, 8'(n), 8'(k), 8'(m)};
   endfunction

   function automatic logic [31:0] ext(input logic [7:0] v);
      return cur_sg ? {{24{v[7]}}, v} : {24'b0, v};
   endfunction

   function automatic longint sv(input logic [7:0] v, input bit sg);
      return sg ? longint'($signed(v)) : longint'(v);
   endfunction

   // Reference: C[i][j] = sum_k A[i][k]*B[k][j] (+ C_old), then clamp or wrap to 8 bits.
   function automatic logic [7:0] ref_elem(input int i, input int j, input int kk,
                                           input bit sg, input bit ac, input bit st);
      longint s;
      s = 0;
      for (int k = 0; k < kk; k++) s += sv(ma[i*8+k], sg) * sv(mb[k*8+j], sg);
      if (ac) s += sv(mc[i*8+j], sg);
      if (st) begin
         if (sg && s > 127)   s = 127;
         if (sg && s < -128)  s = -128;
         if (!sg && s > 255)  s = 255;
         if (!sg && s < 0)    s = 0;
      end
      return s[7:0];
   endfunction

   task automatic model_run(input int m, input int k, input int n, input bit sg, input bit ac, input bit st);
      for (int i = 0; i < m; i++)
         for (int j = 0; j < n; j++)
            mc[i*8+j] = ref_elem(i, j, k, sg, ac, st);
   endtask

   task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
      int n;
      @(negedge clk);
      stb = 1'b1; we = w; adr = a; dat_w = d;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack && n < 8);
      check("ack_wait", 32'(n), 32'd1);
      r = rdt;
      @(posedge clk);
      #1;
      stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] r;
      xfer(1'b1, a, d, r);
   endtask

   task automatic wr_el(input int bank, input int idx, input logic [7:0] v);
      wr(addr(bank, idx), {24'b0, v});
      if (bank == 1) ma[idx] = v;
      if (bank == 2) mb[idx] = v;
      if (bank == 3) mc[idx] = v;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] r;
      xfer(1'b0, a, 32'h0, r);
      check(tag, r, exp);
   endtask

   task automatic start(input int m, input int k, input int n, input bit sg, input bit ac, input bit st);
      wr(addr(0, 0), ctrl_word(m, k, n, 1'b1, sg, ac, st));
      cur_sg = sg;
   endtask

   task automatic wait_irq(input int limit, output int n);
      n = 0;
      while (!irq && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!irq) check("irq_timeout", {31'b0, irq}, 32'd1);
   endtask

   task automatic run(input int m, input int k, input int n, input bit sg, input bit ac,
                      input bit st, input int exp_cycles);
      int nc;
      start(m, k, n, sg, ac, st);
      wait_irq(5000, nc);
      if (exp_cycles >= 0) check("run_cycles", 32'(nc), 32'(exp_cycles));
      wr(addr(4, 0), 32'h2);
      model_run(m, k, n, sg, ac, st);
   endtask

   initial begin
      int nc, m, k, n;
      bit sg, ac, st;
      rst = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; cur_sg = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_ack", {31'b0, ack}, 32'd0);
      check("rst_rdt", rdt, 32'd0);
      check("rst_irq", {31'b0, irq}, 32'd0);
      rd_chk("rst_ctrl", addr(0, 0), 32'd0);
      rd_chk("rst_status", addr(4, 0), 32'd0);
      rd_chk("rst_irqen", addr(5, 0), 32'd0);

      // 2x3 * 3x2 unsigned with interrupt enabled.
      for (int i = 0; i < 2; i++)
         for (int kk = 0; kk < 3; kk++) wr_el(1, i*8+kk, 8'(i*3+kk+1));
      for (int kk = 0; kk < 3; kk++)
         for (int j = 0; j < 2; j++) wr_el(2, kk*8+j, 8'(7+kk*2+j));
      wr(addr(5, 0), 32'h1);
      start(2, 3, 2, 0, 0, 0);
      wait_irq(200, nc);
      check("busy_then_done_cycles", 32'(nc), 32'(2*2*(3+1)+1));
      check("irq_on_done", {31'b0, irq}, 32'd1);
      rd_chk("status_done", addr(4, 0), 32'h2);
      rd_chk("c00", addr(3, 0), 32'd58);
      rd_chk("c01", addr(3, 1), 32'd64);
      rd_chk("c10", addr(3, 8), 32'd139);
      rd_chk("c11", addr(3, 9), 32'd154);
      rd_chk("ctrl_start_reads0", addr(0, 0), ctrl_word(2, 3, 2, 0, 0, 0, 0));
      model_run(2, 3, 2, 0, 0, 0);
      wr(addr(4, 0), 32'h2);
      check("irq_cleared", {31'b0, irq}, 32'd0);
      rd_chk("status_clear", addr(4, 0), 32'd0);

      // Re-run: busy visible, A write while busy dropped.
      start(2, 3, 2, 0, 0, 0);
      rd_chk("status_busy", addr(4, 0), 32'h1);
      wr(addr(1, 0), 32'd99);
      wait_irq(200, nc);
      wr(addr(4, 0), 32'h2);
      model_run(2, 3, 2, 0, 0, 0);
      rd_chk("a_busy_write_dropped", addr(1, 0), 32'd1);
      rd_chk("c00_rerun", addr(3, 0), 32'd58);

      // Signed 8-bit: -128 * -128 saturates to 127, wraps to 0.
      wr_el(1, 0, 8'h80);
      wr_el(2, 0, 8'h80);
      run(1, 1, 1, 1, 0, 1, 1*1*2+1);
      rd_chk("signed_sat", addr(3, 0), 32'h7F);
      rd_chk("a_sign_ext", addr(1, 0), 32'hFFFF_FF80);
      run(1, 1, 1, 1, 0, 0, -1);
      rd_chk("signed_wrap", addr(3, 0), 32'h0);

      // Accumulate: 100 + 2*4 + 3*5, twice.
      wr_el(3, 0, 8'd100);
      wr_el(1, 0, 8'd2);
      wr_el(1, 1, 8'd3);
      wr_el(2, 0, 8'd4);
      wr_el(2, 8, 8'd5);
      run(1, 2, 1, 0, 1, 0, -1);
      rd_chk("accum_1", addr(3, 0), 32'd123);
      run(1, 2, 1, 0, 1, 0, -1);
      rd_chk("accum_2", addr(3, 0), 32'd146);

      // Invalid dimensions.
      start(1, 0, 1, 0, 0, 0);
      rd_chk("err_k0", addr(4, 0), 32'h4);
      rd_chk("c_unchanged_k0", addr(3, 0), 32'd146);
      wr(addr(4, 0), 32'h4);
      rd_chk("err_w1c", addr(4, 0), 32'h0);
      start(MM + 1, 1, 1, 0, 0, 0);
      rd_chk("err_m_big", addr(4, 0), 32'h4);
      check("irq_no_done_on_err", {31'b0, irq}, 32'd0);
      wr(addr(4, 0), 32'h4);

      // Out-of-range index and unused banks.
      wr(addr(1, 64), 32'd5);
      rd_chk("oor_read", addr(1, 64), 32'd0);
      rd_chk("oor_no_alias", addr(1, 0), ext(ma[0]));
      wr(addr(7, 0), 32'hFFFF_FFFF);
      rd_chk("bank6", addr(6, 0), 32'd0);
      rd_chk("bank7", addr(7, 0), 32'd0);

      // 8x8x8 aborted mid-run, then a full run.
      for (int i = 0; i < 64; i++) begin
         wr_el(1, i, 8'($urandom));
         wr_el(2, i, 8'($urandom));
      end
      start(8, 8, 8, 0, 0, 0);
      repeat (100) @(posedge clk);
      wr(addr(5, 0), 32'h8000_0001);
      rd_chk("status_aborted", addr(4, 0), 32'h8);
      check("irq_after_abort", {31'b0, irq}, 32'd0);
      mc[0] = ref_elem(0, 0, 8, 0, 0, 0);
      rd_chk("abort_c00_kept", addr(3, 0), ext(mc[0]));
      wr(addr(4, 0), 32'h8);
      rd_chk("aborted_w1c", addr(4, 0), 32'h0);
      run(8, 8, 8, 1, 0, 1, 8*8*9+1);
      for (int i = 0; i < 64; i++) rd_chk("c_8x8x8", addr(3, i), ext(mc[i]));

      // Randomized shapes and modes.
      for (int t = 0; t < 5; t++) begin
         m  = $urandom_range(1, 8);
         k  = $urandom_range(1, 8);
         n  = $urandom_range(1, 8);
         sg = 1'($urandom);
         ac = 1'($urandom);
         st = 1'($urandom);
         for (int i = 0; i < m; i++)
            for (int kk = 0; kk < k; kk++) wr_el(1, i*8+kk, 8'($urandom));
         for (int kk = 0; kk < k; kk++)
            for (int j = 0; j < n; j++) wr_el(2, kk*8+j, 8'($urandom));
         run(m, k, n, sg, ac, st, m*n*(k+1)+1);
         for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++) rd_chk("c_random", addr(3, i*8+j), ext(mc[i*8+j]));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
